// File: rtl/argmin_tree.sv
// Masked argmin over 2**WIDTH keys: pairwise halving, one level per index bit.
// The lower index wins ties, and a slot whose flag is clear never wins.
module argmin_tree #(
    parameter int WIDTH  = 3,
    parameter int LENGTH = 10
) (
    input  logic [(LENGTH << WIDTH)-1:0] i_keys,
    input  logic [(1 << WIDTH)-1:0]      i_flags,
    output logic [WIDTH-1:0]             o_idx,
    output logic [LENGTH-1:0]            o_key,
    output logic                         o_valid
);
    localparam int N = 1 << WIDTH;

    for (genvar lv = 0; lv <= WIDTH; lv++) begin : g_lvl
        localparam int NN = N >> lv;
        logic [LENGTH-1:0] w_key [NN];
        logic [WIDTH-1:0]  w_idx [NN];
        logic              w_vld [NN];

        if (lv == 0) begin : g_leaf
            for (genvar j = 0; j < NN; j++) begin : g_n
                assign w_key[j] = i_keys[j*LENGTH +: LENGTH];
                assign w_idx[j] = WIDTH'(j);
                assign w_vld[j] = i_flags[j];
            end
        end else begin : g_node
            for (genvar j = 0; j < NN; j++) begin : g_n
                // The left child covers the lower slot indices, so it takes ties.
                logic w_pick_l;
                assign w_pick_l = g_lvl[lv-1].w_vld[2*j] &&
                                  (!g_lvl[lv-1].w_vld[2*j+1] ||
                                   (g_lvl[lv-1].w_key[2*j] <= g_lvl[lv-1].w_key[2*j+1]));
                assign w_key[j] = w_pick_l ? g_lvl[lv-1].w_key[2*j] : g_lvl[lv-1].w_key[2*j+1];
                assign w_idx[j] = w_pick_l ? g_lvl[lv-1].w_idx[2*j] : g_lvl[lv-1].w_idx[2*j+1];
                assign w_vld[j] = g_lvl[lv-1].w_vld[2*j] | g_lvl[lv-1].w_vld[2*j+1];
            end
        end
    end

    assign o_idx   = g_lvl[WIDTH].w_idx[0];
    assign o_key   = g_lvl[WIDTH].w_key[0];
    assign o_valid = g_lvl[WIDTH].w_vld[0];
endmodule

// File: rtl/min_pqueue.sv
// Slot-based min priority queue: pushes fill the lowest free slot, pops remove the
// smallest occupied key and present it one cycle later on pop_data/pop_index.
module min_pqueue #(
    parameter int WIDTH  = 3,
    parameter int LENGTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [LENGTH-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_valid,
    output logic [LENGTH-1:0] pop_data,
    output logic [WIDTH-1:0]  pop_index,
    output logic [WIDTH:0]    count,
    output logic              full,
    output logic              empty
);
    localparam int N = 1 << WIDTH;
    localparam logic [WIDTH:0] CAP = (WIDTH+1)'(N);

    logic [LENGTH-1:0]         r_key [N];
    logic [N-1:0]              r_occ;
    logic [WIDTH:0]            r_count;
    logic                      r_pop_valid;
    logic [LENGTH-1:0]         r_pop_data;
    logic [WIDTH-1:0]          r_pop_index;

    logic [(LENGTH << WIDTH)-1:0] w_keys_flat;
    logic [WIDTH-1:0]          w_min_idx;
    logic [LENGTH-1:0]         w_min_key;
    logic                      w_min_vld;
    logic [WIDTH-1:0]          w_free_idx;
    logic                      w_push_acc;
    logic                      w_pop_acc;
    logic [N-1:0]              w_occ_nxt;

    for (genvar j = 0; j < N; j++) begin : g_flat
        assign w_keys_flat[j*LENGTH +: LENGTH] = r_key[j];
    end

    argmin_tree #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) u_argmin (
        .i_keys  (w_keys_flat),
        .i_flags (r_occ),
        .o_idx   (w_min_idx),
        .o_key   (w_min_key),
        .o_valid (w_min_vld)
    );

    // Lowest-index free slot; descending scan so the last hit is the lowest.
    always_comb begin
        w_free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!r_occ[i]) w_free_idx = WIDTH'(i);
        end
    end

    assign full       = (r_count == CAP);
    assign empty      = (r_count == '0);
    assign push_ready = !full;
    assign w_push_acc = push_valid && !full;
    assign w_pop_acc  = pop_req && w_min_vld;

    // Pop and push act on the pre-edge view, so their slots never collide.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_pop_acc)  w_occ_nxt[w_min_idx]  = 1'b0;
        if (w_push_acc) w_occ_nxt[w_free_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) r_key[w_free_idx] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ       <= '0;
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
            r_pop_index <= '0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_pop_valid <= w_pop_acc;
            if (w_pop_acc) begin
                r_pop_data  <= w_min_key;
                r_pop_index <= w_min_idx;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count     = r_count;
    assign pop_valid = r_pop_valid;
    assign pop_data  = r_pop_data;
    assign pop_index = r_pop_index;
endmodule

// File: doc/min_pqueue.md
MIN_PQUEUE -- requirements
Module: min_pqueue

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving log2 of slot count (2**WIDTH slots).
REQ-002 SHALL have parameter LENGTH, default 10, giving the key width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port push_valid, input, 1 bit: writer offers a key.
REQ-006 SHALL have port push_data, input, LENGTH bits: key to insert.
REQ-007 SHALL have port push_ready, output, 1 bit: insert accepted this cycle when high with push_valid.
REQ-008 SHALL have port pop_req, input, 1 bit: reader requests removal of the minimum key.
REQ-009 SHALL have port pop_valid, output, 1 bit: pop_data and pop_index hold a removed entry.
REQ-010 SHALL have port pop_data, output, LENGTH bits: removed minimum key.
REQ-011 SHALL have port pop_index, output, WIDTH bits: slot the key was removed from.
REQ-012 SHALL have port count, output, WIDTH+1 bits: number of occupied slots.
REQ-013 SHALL have ports full and empty, outputs, 1 bit each: count == 2**WIDTH and count == 0 respectively.

Function
REQ-014 SHALL hold 2**WIDTH key registers, each with an occupied flag.
REQ-015 SHALL drive push_ready = !full combinationally.
REQ-016 SHALL, on push_valid && push_ready, write push_data into the lowest-index free slot and set its flag at the clock edge.
REQ-017 SHALL, on pop_req && !empty, clear the flag of the occupied slot holding the smallest key (unsigned compare), ties resolved to the lowest index.
REQ-018 SHALL register the popped key and slot into pop_data/pop_index with pop_valid = 1 exactly one cycle after the accepted pop_req.
REQ-019 SHALL hold pop_valid = 0 in any cycle not following an accepted pop; pop_data/pop_index SHALL hold their last value.
REQ-020 SHALL ignore pop_req when empty (no state change, pop_valid = 0 next cycle).
REQ-021 SHALL ignore push_valid when full; the key is not stored and count is unchanged.
REQ-022 SHALL, on simultaneous accepted push and pop, select the pop minimum from entries occupied before the edge (incoming key excluded) and place the push in a slot free before the edge; count is unchanged.
REQ-023 SHALL, when full with simultaneous push_valid and pop_req, perform the pop only (push_ready = 0).
REQ-024 SHALL update count by +1 (push only), -1 (pop only), 0 (both or neither); count never wraps.
REQ-025 SHALL never select an unoccupied slot as minimum regardless of its stale key value.

Reset
REQ-026 SHALL, while rst_n = 0, clear all occupied flags, count = 0, pop_valid = 0, pop_data = 0, pop_index = 0, independent of clk.
REQ-027 SHALL drop a pending pop result when reset asserts mid-operation; the first cycle after release SHALL show empty = 1, push_ready = 1.

Structure
REQ-028 SHALL place no typedefs in a shared package; WIDTH and LENGTH are module parameters only.
REQ-029 SHALL instantiate one combinational sub-module, argmin_tree, computing the masked argmin index over the 2**WIDTH keys and flags (recursive pairwise halving, lower index wins ties).
REQ-030 SHALL contain the free-slot priority encoder, count and output registers in min_pqueue itself.

Verification
REQ-031 SHALL cover: push 30,10,20 then pop x3 -> pop_data 10,20,30 on the cycles after each pop_req; pop_index 1,2,0.
REQ-032 SHALL cover: fill 8 slots with 7..0, push 99 while full -> push_ready = 0, count = 8, later pops never return 99.
REQ-033 SHALL cover: with slots {5,9}, push 1 and pop in the same cycle -> pop_data = 5, count stays 2, next pop returns 1.
REQ-034 SHALL cover: push 4,4 -> pops return pop_index 0 then 1 (tie to lowest index).
REQ-035 SHALL cover: pop on empty -> pop_valid = 0, count = 0; push 3, pop, pop -> second pop yields pop_valid = 0.
REQ-036 SHALL cover: assert rst_n = 0 in the cycle after pop_req with 3 entries -> pop_valid = 0, count = 0, empty = 1 immediately, without a clock edge.
